sshr_result_stage: RTL and testbench
====================================

Name: sshr_result_stage

Overview:
- Elastic register stage directly downstream of the combinational signed-shift-right datapath component.
- Captures each shifter result with a valid/ready handshake, derives status flags, and presents them to the next datapath consumer.
- Uses a 2-entry skid buffer, so `in_ready` is purely registered and there is no combinational path from `out_ready` to `in_ready`.

Parameters:
- DATAWIDTH, 8, width of the shifter result and of the shift amount.
- CNTWIDTH, 16, width of the optional transfer counter.

Ports:
- Clk  input  1  clock; all state updates on rising edge.
- Rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  shifter result and shift amount are valid.
- in_ready  output  1  stage can accept; registered.
- in_d  input  DATAWIDTH  shifter result (signed).
- in_sh_amt  input  DATAWIDTH  shift amount applied by the shifter; interpreted here as unsigned.
- out_valid  output  1  output entry valid.
- out_ready  input  1  consumer accepts.
- out_d  output  DATAWIDTH  buffered result.
- out_neg  output  1  result MSB.
- out_zero  output  1  result equals 0.
- out_sat  output  1  in_sh_amt >= DATAWIDTH (shift fully saturated).
- out_xfer_cnt  output  CNTWIDTH  present only with the optional feature.

Behaviour:
- Reset (Rst = 0, asynchronous):
  - state = EMPTY.
  - in_ready = 1, out_valid = 0.
  - out_d, out_neg, out_zero, out_sat = 0; skid entry = 0.
- Handshakes:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
  - in_d / in_sh_amt may change freely when in_valid = 0.
  - out_* must hold stable while out_valid & !out_ready.
- Flags: computed from in_d / in_sh_amt at capture and stored alongside the data, never recomputed from out_d. One entry = {d, neg, zero, sat}, DATAWIDTH + 3 bits.
- Storage: main register drives out_*; skid register holds the overflow entry.
- State EMPTY (out_valid = 0, in_ready = 1):
  - in xfer -> load main, go ONE.
- State ONE (out_valid = 1, in_ready = 1):
  - in xfer & out xfer -> load main with new entry, stay ONE.
  - in xfer only -> load skid, go FULL.
  - out xfer only -> go EMPTY.
- State FULL (out_valid = 1, in_ready = 0):
  - out xfer -> main <= skid, go ONE.
  - in_valid is ignored in FULL.
- Latency: 1 cycle from input transfer to out_valid when EMPTY; no bubble under continuous traffic; throughput 1 entry/cycle.
- Ordering: strict FIFO; no entry dropped or duplicated.
- Reset asserted mid-operation: all entries discarded, outputs to reset values immediately (asynchronously).
- in_ready is derived only from the state register.

Optional Feature:
- Macro SSHR_STAGE_CNT_EN.
- Defined:
  - out_xfer_cnt increments by 1 on each output transfer and wraps from 2^CNTWIDTH-1 to 0.
  - Reset value 0; asynchronous reset as for the rest of the stage.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package:
  - state encoding constants EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2.
  - entry typedef {d, neg, zero, sat} with a DATAWIDTH-dependent width.
- One sub-module is natural: sshr_flag_gen, a combinational block (d, sh_amt -> neg, zero, sat) reused by the other shift stages.

Test Plan:
- Reset released, in_d = 8'hF0, in_sh_amt = 2, in_valid pulse, out_ready = 1 -> next cycle out_valid = 1, out_d = F0, out_neg = 1, out_zero = 0, out_sat = 0; following cycle out_valid = 0.
- in_d = 0, in_sh_amt = 8 -> out_zero = 1, out_sat = 1; in_sh_amt = 8'hFF -> out_sat = 1 (unsigned interpretation).
- out_ready = 0, push 01, 02 -> in_ready = 0 after the second push, out_d stable at 01; raise out_ready -> out_d 01 then 02, in_ready = 1 one cycle after the first pop.
- Continuous in_valid = out_ready = 1 streaming 1..20 -> outputs 1..20 in order, one per cycle, no bubbles.
- FULL with in_valid = 1 on new data 03 -> 03 is not accepted until in_ready = 1; output sequence contains no 03 before 01, 02.
- Assert Rst mid-stream while FULL -> out_valid = 0 and in_ready = 1 immediately; with SSHR_STAGE_CNT_EN, 300 transfers at CNTWIDTH = 8 -> out_xfer_cnt = 44.

Source files
------------

// File: rtl/sshr_result_stage_pkg.sv
// Shared types for the signed-shift-right result stages.
// State encoding and the buffered entry layout.
package sshr_result_stage_pkg;

    localparam int unsigned SSHR_DW = 8;
    localparam int unsigned SSHR_FLAG_BITS = 3;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } sshr_state_t;

    // Entry at the default result width; stages with another width
    // declare the same layout locally from their own parameter.
    typedef struct packed {
        logic [SSHR_DW-1:0] d;
        logic               neg;
        logic               zero;
        logic               sat;
    } sshr_entry_t;

endpackage

// File: rtl/sshr_result_stage_flag_gen.sv
// Status flags for a signed-shift-right result.
// The shift amount is treated as unsigned.
module sshr_flag_gen #(
    parameter int unsigned DATAWIDTH = 8
) (
    input  logic [DATAWIDTH-1:0] in_d,
    input  logic [DATAWIDTH-1:0] in_sh_amt,
    output logic                 out_neg,
    output logic                 out_zero,
    output logic                 out_sat
);

    // One extra bit so DATAWIDTH itself is always representable.
    localparam logic [DATAWIDTH:0] SAT_LIMIT = (DATAWIDTH+1)'(DATAWIDTH);

    assign out_neg  = in_d[DATAWIDTH-1];
    assign out_zero = (in_d == '0);
    assign out_sat  = ({1'b0, in_sh_amt} >= SAT_LIMIT);

endmodule

// File: rtl/sshr_result_stage.sv
// Elastic 2-entry skid stage after the signed-shift-right datapath.
// Optional transfer counter: define SSHR_STAGE_CNT_EN.
module sshr_result_stage
    import sshr_result_stage_pkg::*;
#(
    parameter int unsigned DATAWIDTH = 8
`ifdef SSHR_STAGE_CNT_EN
    ,
    parameter int unsigned CNTWIDTH  = 16
`endif
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATAWIDTH-1:0] in_d,
    input  logic [DATAWIDTH-1:0] in_sh_amt,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATAWIDTH-1:0] out_d,
    output logic                 out_neg,
    output logic                 out_zero,
    output logic                 out_sat
`ifdef SSHR_STAGE_CNT_EN
    ,
    output logic [CNTWIDTH-1:0]  out_xfer_cnt
`endif
);

    typedef struct packed {
        logic [DATAWIDTH-1:0] d;
        logic                 neg;
        logic                 zero;
        logic                 sat;
    } entry_t;

    sshr_state_t r_state;
    entry_t      r_main;
    entry_t      r_skid;
    entry_t      w_entry;
    logic        w_in_xfer;
    logic        w_out_xfer;

    sshr_flag_gen #(
        .DATAWIDTH (DATAWIDTH)
    ) u_flags (
        .in_d      (in_d),
        .in_sh_amt (in_sh_amt),
        .out_neg   (w_entry.neg),
        .out_zero  (w_entry.zero),
        .out_sat   (w_entry.sat)
    );

    assign w_entry.d  = in_d;
    assign in_ready   = (r_state != FULL);
    assign out_valid  = (r_state != EMPTY);
    assign w_in_xfer  = in_valid & in_ready;
    assign w_out_xfer = out_valid & out_ready;

    assign out_d      = r_main.d;
    assign out_neg    = r_main.neg;
    assign out_zero   = r_main.zero;
    assign out_sat    = r_main.sat;

    // Skid FSM: main feeds the consumer, skid absorbs one extra entry.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state <= EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
        end else begin
            unique case (r_state)
                EMPTY: begin
                    if (w_in_xfer) begin
                        r_main  <= w_entry;
                        r_state <= ONE;
                    end
                end
                ONE: begin
                    if (w_in_xfer && w_out_xfer) begin
                        r_main  <= w_entry;
                    end else if (w_in_xfer) begin
                        r_skid  <= w_entry;
                        r_state <= FULL;
                    end else if (w_out_xfer) begin
                        r_state <= EMPTY;
                    end
                end
                FULL: begin
                    if (w_out_xfer) begin
                        r_main  <= r_skid;
                        r_state <= ONE;
                    end
                end
                default: r_state <= EMPTY;
            endcase
        end
    end

`ifdef SSHR_STAGE_CNT_EN
    logic [CNTWIDTH-1:0] r_cnt;

    // Count output transfers, wrapping naturally at full scale.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_cnt <= '0;
        end else if (w_out_xfer) begin
            r_cnt <= r_cnt + CNTWIDTH'(1);
        end
    end

    assign out_xfer_cnt = r_cnt;
`endif

endmodule

// File: tb/tb_sshr_result_stage.sv
// Directed self-checking bench for sshr_result_stage.
// Counter scenario runs when SSHR_STAGE_CNT_EN is defined.
module tb_sshr_result_stage;

    logic       Clk;
    logic       Rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_d;
    logic [7:0] in_sh_amt;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_d;
    logic       out_neg;
    logic       out_zero;
    logic       out_sat;
`ifdef SSHR_STAGE_CNT_EN
    logic [7:0] out_xfer_cnt;
`endif

    int n_checks;
    int n_pass;

    sshr_result_stage #(
        .DATAWIDTH (8)
`ifdef SSHR_STAGE_CNT_EN
        ,
        .CNTWIDTH  (8)
`endif
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_d      (in_d),
        .in_sh_amt (in_sh_amt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_d     (out_d),
        .out_neg   (out_neg),
        .out_zero  (out_zero),
        .out_sat   (out_sat)
`ifdef SSHR_STAGE_CNT_EN
        ,
        .out_xfer_cnt (out_xfer_cnt)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Rst = 1'b0;
        in_valid = 1'b0;
        in_d = 8'h00;
        in_sh_amt = 8'h00;
        out_ready = 1'b0;
        #12;
        n_checks++;
        if ({in_ready, out_valid} !== 2'b10) $display("FAIL reset_hs: got rdy/vld %b expected 10", {in_ready, out_valid});
        else n_pass++;
        n_checks++;
        if ({out_d, out_neg, out_zero, out_sat} !== 11'h0) $display("FAIL reset_out: got %h expected 000", {out_d, out_neg, out_zero, out_sat});
        else n_pass++;
        Rst = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        in_d = 8'hF0;
        in_sh_amt = 8'd2;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, out_d, out_neg, out_zero, out_sat} !== {1'b1, 8'hF0, 3'b100}) $display("FAIL basic: got v=%b d=%h nzs=%b expected v=1 d=f0 nzs=100", out_valid, out_d, {out_neg, out_zero, out_sat});
        else n_pass++;
        tick();
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL basic_drain: got out_valid %b expected 0", out_valid);
        else n_pass++;
    endtask

    task automatic test_flags();
        logic [7:0] dv[3] = '{8'h00, 8'h7F, 8'h80};
        logic [7:0] sv[3] = '{8'd8, 8'hFF, 8'd7};
        logic [2:0] ev[3] = '{3'b011, 3'b001, 3'b100};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_d = dv[i];
            in_sh_amt = sv[i];
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            n_checks++;
            if ({out_valid, out_d, out_neg, out_zero, out_sat} !== {1'b1, dv[i], ev[i]}) $display("FAIL flags[%0d]: got v=%b d=%h nzs=%b expected v=1 d=%h nzs=%b", i, out_valid, out_d, {out_neg, out_zero, out_sat}, dv[i], ev[i]);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_sh_amt = 8'd0;
        in_d = 8'h01;
        in_valid = 1'b1;
        tick();
        n_checks++;
        if ({in_ready, out_valid, out_d} !== {2'b11, 8'h01}) $display("FAIL bp_one: got rdy=%b vld=%b d=%h expected 1 1 01", in_ready, out_valid, out_d);
        else n_pass++;
        in_d = 8'h02;
        tick();
        in_valid = 1'b0;
        n_checks++;
        if ({in_ready, out_valid, out_d} !== {2'b01, 8'h01}) $display("FAIL bp_full: got rdy=%b vld=%b d=%h expected 0 1 01", in_ready, out_valid, out_d);
        else n_pass++;
        tick();
        n_checks++;
        if ({in_ready, out_d} !== {1'b0, 8'h01}) $display("FAIL bp_hold: got rdy=%b d=%h expected 0 01", in_ready, out_d);
        else n_pass++;
        out_ready = 1'b1;
        tick();
        n_checks++;
        if ({in_ready, out_valid, out_d} !== {2'b11, 8'h02}) $display("FAIL bp_pop1: got rdy=%b vld=%b d=%h expected 1 1 02", in_ready, out_valid, out_d);
        else n_pass++;
        tick();
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL bp_pop2: got out_valid %b expected 0", out_valid);
        else n_pass++;
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        in_sh_amt = 8'd1;
        in_d = 8'd1;
        in_valid = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c < 20) in_d = 8'(c + 1);
            else in_valid = 1'b0;
            n_checks++;
            if ({out_valid, in_ready, out_d} !== {2'b11, 8'(c)}) $display("FAIL stream[%0d]: got vld=%b rdy=%b d=%h expected 1 1 %h", c, out_valid, in_ready, out_d, 8'(c));
            else n_pass++;
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL stream_end: got out_valid %b expected 0", out_valid);
        else n_pass++;
    endtask

    task automatic test_full_hold();
        logic [7:0] seen[$];
        logic [7:0] exp_seq[3] = '{8'h01, 8'h02, 8'h03};
        bit         acc;
        out_ready = 1'b0;
        in_sh_amt = 8'd0;
        in_d = 8'h01;
        in_valid = 1'b1;
        tick();
        in_d = 8'h02;
        tick();
        in_d = 8'h03;
        tick();
        tick();
        n_checks++;
        if ({in_ready, out_d} !== {1'b0, 8'h01}) $display("FAIL hold_full: got rdy=%b d=%h expected 0 01", in_ready, out_d);
        else n_pass++;
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (out_valid && out_ready) seen.push_back(out_d);
            acc = in_valid && in_ready;
            tick();
            if (acc) in_valid = 1'b0;
        end
        n_checks++;
        if (seen.size() != 3) $display("FAIL hold_count: got %0d entries expected 3", seen.size());
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (i >= seen.size()) $display("FAIL hold_seq[%0d]: got none expected %h", i, exp_seq[i]);
            else if (seen[i] !== exp_seq[i]) $display("FAIL hold_seq[%0d]: got %h expected %h", i, seen[i], exp_seq[i]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_sh_amt = 8'd9;
        in_d = 8'hAA;
        in_valid = 1'b1;
        tick();
        in_d = 8'hBB;
        tick();
        in_valid = 1'b0;
        n_checks++;
        if ({in_ready, out_valid} !== 2'b01) $display("FAIL rstmid_pre: got rdy/vld %b expected 01", {in_ready, out_valid});
        else n_pass++;
        #2;
        Rst = 1'b0;
        #1;
        n_checks++;
        if ({in_ready, out_valid, out_d, out_neg, out_zero, out_sat} !== {2'b10, 11'h0}) $display("FAIL rstmid: got rdy=%b vld=%b d=%h nzs=%b expected 1 0 00 000", in_ready, out_valid, out_d, {out_neg, out_zero, out_sat});
        else n_pass++;
        tick();
        Rst = 1'b1;
        out_ready = 1'b1;
        tick();
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL rstmid_post: got out_valid %b expected 0", out_valid);
        else n_pass++;
    endtask

`ifdef SSHR_STAGE_CNT_EN
    task automatic test_cnt();
        n_checks++;
        if (out_xfer_cnt !== 8'd0) $display("FAIL cnt_reset: got %0d expected 0", out_xfer_cnt);
        else n_pass++;
        out_ready = 1'b1;
        in_sh_amt = 8'd3;
        in_valid = 1'b1;
        for (int c = 0; c < 300; c++) begin
            in_d = 8'(c);
            tick();
        end
        in_valid = 1'b0;
        tick();
        n_checks++;
        if ({out_valid, out_xfer_cnt} !== {1'b0, 8'd44}) $display("FAIL cnt_wrap: got vld=%b cnt=%0d expected 0 44", out_valid, out_xfer_cnt);
        else n_pass++;
    endtask
`endif

    initial begin
        n_checks = 0;
        n_pass = 0;
        test_reset();
        test_basic();
        test_flags();
        test_backpressure();
        test_stream();
        test_full_hold();
        test_reset_mid();
`ifdef SSHR_STAGE_CNT_EN
        test_cnt();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
